quaternion_operand_loader: RTL and testbench
============================================

Name: quaternion_operand_loader

Overview:
Transmit-side feeder for the quaternion multiplier array. It accepts a serial valid/ready stream of eight IEEE-754 single-precision words: quaternion A (w,x,y,z), then quaternion B (w,x,y,z). It registers the eight words and presents them in parallel, with per-operand valid strobes, to the 16-multiplier product array. It then waits for the array's result-valid, enforcing framing and a result timeout.

Parameters:
DATA_W, 32, operand word width (float32)
TIMEOUT_CYC, 64, max cycles in WAIT before err_timeout; legal range 2..65535
CNT_W, 16, width of frames_issued counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
s_valid  in  1  upstream word valid
s_data  in  DATA_W  upstream word
s_last  in  1  marks 8th word of frame
s_ready  out  1  loader accepts word this cycle
q00_valid..q03_valid  out  1 each  operand-A strobes
q00..q03  out  DATA_W each  quaternion A w,x,y,z
q10_valid..q13_valid  out  1 each  operand-B strobes
q10..q13  out  DATA_W each  quaternion B w,x,y,z
res_valid  in  1  result valid from multiplier array
busy  out  1  high in ISSUE or WAIT
done  out  1  1-cycle pulse, frame result received
err_framing  out  1  1-cycle pulse, bad s_last placement
err_timeout  out  1  1-cycle pulse, no res_valid within TIMEOUT_CYC
frames_issued  out  CNT_W  count of ISSUE cycles, wraps

Behaviour:
- Reset (async assert, sync deassert by clk): all outputs 0, all operand registers 0, index 0, state LOAD. s_ready is 0 while rst is high and 1 on the first cycle after release.
- Beat accepted = s_valid & s_ready. Words 0..3 go to q00..q03, words 4..7 go to q10..q13, in index order.
- States: LOAD, DISCARD, ISSUE, WAIT.
- LOAD: s_ready=1.
  - Accepted beat at index<7 with s_last=0: index++.
  - Accepted beat at index<7 with s_last=1: err_framing pulses next cycle; index returns to 0; partial frame is dropped; stay in LOAD.
  - Accepted beat at index 7 with s_last=1: go to ISSUE; index returns to 0.
  - Accepted beat at index 7 with s_last=0: err_framing pulses; go to DISCARD.
- DISCARD: s_ready=1. Beats are consumed and ignored until an accepted beat with s_last=1, then go to LOAD with index 0. No further err_framing pulses while in DISCARD.
- ISSUE: exactly one cycle. s_ready=0. All eight qNN_valid are high together and frames_issued increments (0xFFFF wraps to 0x0000). Next state WAIT.
- Latency: last beat accepted in cycle N -> strobes high in cycle N+1.
- Operand data outputs change only on accepted beats into the corresponding slot. Slots are written in LOAD only, never in ISSUE or WAIT.
- WAIT: s_ready=0. A watchdog counter clears on entry and increments every cycle.
  - res_valid=1: done pulses next cycle; go to LOAD (s_ready=1 next cycle).
  - Counter reaches TIMEOUT_CYC-1 without res_valid: err_timeout pulses next cycle; go to LOAD.
  - res_valid and timeout in the same cycle: res_valid wins; done pulses, not err_timeout.
- res_valid outside WAIT is ignored.
- busy = (state==ISSUE)|(state==WAIT).
- rst asserted mid-frame or mid-WAIT: immediate abort. No done or error pulse, and frames_issued clears.

Decomposition:
- Package quat_pkg:
  - DATA_W
  - NUM_WORDS=8
  - IDX_W=3
  - state enum {LOAD, DISCARD, ISSUE, WAIT}
  - float32 constants ONE=32'h3F800000 and TWO=32'h40000000 for benches
- One sub-module, quat_watchdog: clear/enable inputs, expire output, parameter TIMEOUT_CYC. It is instantiated once for the WAIT timeout.

Test Plan:
- Clean frame: send 3F800000,40000000,40400000,40800000 then 3F800000,0,0,0 with s_last on beat 8 -> cycle after last beat, all 8 strobes high 1 cycle; q00=3F800000, q03=40800000, q10=3F800000; frames_issued=1; s_ready=0 until res_valid.
- Result: in WAIT, drive res_valid 5 cycles after ISSUE -> done high exactly 1 cycle later; s_ready=1 in that same cycle; busy=0.
- Early last: s_last on beat 3 -> err_framing pulses once; no strobes; the next full 8-word frame issues normally with its own values.
- Missing last: 8 beats with no s_last, then 2 more beats with s_last on the 2nd -> single err_framing pulse; no ISSUE; the following clean frame issues.
- Timeout: TIMEOUT_CYC=4, never assert res_valid -> err_timeout pulses 4 cycles after entering WAIT; done stays 0; s_ready=1 the next cycle. Repeat with res_valid on the expiry cycle -> done=1, err_timeout=0.
- Reset/wrap: preload frames_issued near wrap (issue 65536 frames, or force the counter) -> 0xFFFF to 0x0000. Assert rst at beat 5 -> all outputs 0 asynchronously, with no pulses.

Source files
------------

// File: rtl/quat_pkg.sv
// Shared definitions for the quaternion operand loader.
//   DATA_W     operand word width (float32)
//   NUM_WORDS  words per frame (quaternion A then quaternion B)
//   IDX_W      width of the in-frame word index
//   state_t    loader FSM states
//   ONE / TWO  float32 constants handy for stimulus
package quat_pkg;

    localparam int DATA_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        DISCARD = 2'd1,
        ISSUE   = 2'd2,
        WAIT    = 2'd3
    } state_t;

    localparam logic [31:0] ONE = 32'h3F80_0000;
    localparam logic [31:0] TWO = 32'h4000_0000;

endpackage

// File: rtl/quat_watchdog.sv
// Result watchdog for the operand loader.
//   clk, rst   clock, asynchronous active-high reset
//   clear      zero the counter (asserted the cycle before waiting starts)
//   enable     count this cycle
//   expire     high while enabled and the counter sits at TIMEOUT_CYC-1
module quat_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // The owner leaves its wait state on expiry, so the counter never
    // needs to saturate.
    assign expire = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/quaternion_operand_loader.sv
// Serial-to-parallel operand feeder for the quaternion product array.
// Collects eight float32 words (A.w,A.x,A.y,A.z,B.w,B.x,B.y,B.z), issues
// them with one-cycle strobes, then waits for the array's result.
//
// Handshake: a word transfers on a rising clk edge when s_valid and s_ready
// are both high; s_valid/s_data/s_last must hold until that edge. s_ready is
// high only in LOAD and DISCARD, and low whenever rst is high.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   s_valid, s_data, s_last    upstream word stream (s_last on word 8)
//   s_ready                    loader accepts a word this cycle
//   q00..q03 / q00_valid..     quaternion A words and strobes
//   q10..q13 / q10_valid..     quaternion B words and strobes
//   res_valid                  result valid from the product array
//   busy                       high in ISSUE or WAIT
//   done                       one-cycle pulse, result received
//   err_framing                one-cycle pulse, s_last misplaced
//   err_timeout                one-cycle pulse, result never arrived
//   frames_issued              count of ISSUE cycles, wraps
//   dbg_state                  current FSM state
module quaternion_operand_loader
    import quat_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              q00_valid,
    output logic              q01_valid,
    output logic              q02_valid,
    output logic              q03_valid,
    output logic [DATA_W-1:0] q00,
    output logic [DATA_W-1:0] q01,
    output logic [DATA_W-1:0] q02,
    output logic [DATA_W-1:0] q03,
    output logic              q10_valid,
    output logic              q11_valid,
    output logic              q12_valid,
    output logic              q13_valid,
    output logic [DATA_W-1:0] q10,
    output logic [DATA_W-1:0] q11,
    output logic [DATA_W-1:0] q12,
    output logic [DATA_W-1:0] q13,
    input  logic              res_valid,
    output logic              busy,
    output logic              done,
    output logic              err_framing,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  frames_issued,
    output state_t            dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  opnd_q [NUM_WORDS];
    logic [CNT_W-1:0]   frames_q;
    logic               done_q, framing_q, timeout_q;
    logic               done_d, framing_d, timeout_d;
    logic               wr_en;
    logic               accept;
    logic               expire;
    logic               in_issue;

    // rst gates s_ready directly so no beat can be taken while reset is held.
    assign s_ready  = !rst && ((state_q == LOAD) || (state_q == DISCARD));
    assign accept   = s_valid && s_ready;
    assign in_issue = (state_q == ISSUE);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        framing_d = 1'b0;
        timeout_d = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (idx_q != LAST_IDX) begin
                        if (s_last) begin
                            // Short frame: drop it and restart at word 0.
                            framing_d = 1'b1;
                            idx_d     = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        idx_d = '0;
                        if (s_last) begin
                            state_d = ISSUE;
                        end else begin
                            // Long frame: flag once, then swallow to s_last.
                            framing_d = 1'b1;
                            state_d   = DISCARD;
                        end
                    end
                end
            end
            DISCARD: begin
                if (accept && s_last) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A result arriving on the expiry cycle still counts as done.
                if (res_valid) begin
                    done_d  = 1'b1;
                    state_d = LOAD;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD;
            idx_q     <= '0;
            frames_q  <= '0;
            done_q    <= 1'b0;
            framing_q <= 1'b0;
            timeout_q <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                opnd_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            framing_q <= framing_d;
            timeout_q <= timeout_d;
            if (wr_en) begin
                opnd_q[idx_q] <= s_data;
            end
            // Count on the edge into ISSUE so the new total is visible
            // alongside the strobes.
            if ((state_q == LOAD) && (state_d == ISSUE)) begin
                frames_q <= frames_q + CNT_W'(1);
            end
        end
    end

    quat_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (in_issue),
        .enable (state_q == WAIT),
        .expire (expire)
    );

    assign q00 = opnd_q[0];
    assign q01 = opnd_q[1];
    assign q02 = opnd_q[2];
    assign q03 = opnd_q[3];
    assign q10 = opnd_q[4];
    assign q11 = opnd_q[5];
    assign q12 = opnd_q[6];
    assign q13 = opnd_q[7];

    assign q00_valid = in_issue;
    assign q01_valid = in_issue;
    assign q02_valid = in_issue;
    assign q03_valid = in_issue;
    assign q10_valid = in_issue;
    assign q11_valid = in_issue;
    assign q12_valid = in_issue;
    assign q13_valid = in_issue;

    assign busy          = (state_q == ISSUE) || (state_q == WAIT);
    assign done          = done_q;
    assign err_framing   = framing_q;
    assign err_timeout   = timeout_q;
    assign frames_issued = frames_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_quaternion_operand_loader.sv
// Directed bench for quaternion_operand_loader (TIMEOUT_CYC=4, CNT_W=4).
module tb_quaternion_operand_loader;
    import quat_pkg::*;

    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int FW  = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [31:0]   s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          q00_valid, q01_valid, q02_valid, q03_valid;
    logic          q10_valid, q11_valid, q12_valid, q13_valid;
    logic [31:0]   q00, q01, q02, q03, q10, q11, q12, q13;
    logic          res_valid = 1'b0;
    logic          busy, done, err_framing, err_timeout;
    logic [CW-1:0] frames_issued;
    state_t        dbg_state;

    logic [FW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            issue_cnt = 0;
    int            frames_sent = 0;
    int            done_cnt = 0;
    int            fr_cnt = 0;
    int            to_cnt = 0;

    quaternion_operand_loader #(
        .DATA_W      (32),
        .TIMEOUT_CYC (TO),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .q00_valid     (q00_valid),
        .q01_valid     (q01_valid),
        .q02_valid     (q02_valid),
        .q03_valid     (q03_valid),
        .q00           (q00),
        .q01           (q01),
        .q02           (q02),
        .q03           (q03),
        .q10_valid     (q10_valid),
        .q11_valid     (q11_valid),
        .q12_valid     (q12_valid),
        .q13_valid     (q13_valid),
        .q10           (q10),
        .q11           (q11),
        .q12           (q12),
        .q13           (q13),
        .res_valid     (res_valid),
        .busy          (busy),
        .done          (done),
        .err_framing   (err_framing),
        .err_timeout   (err_timeout),
        .frames_issued (frames_issued),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_frame(input logic [31:0] w0, input logic [31:0] w1,
                                               input logic [31:0] w2, input logic [31:0] w3,
                                               input logic [31:0] w4, input logic [31:0] w5,
                                               input logic [31:0] w6, input logic [31:0] w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    function automatic logic [FW-1:0] operands();
        return {q13, q12, q11, q10, q03, q02, q01, q00};
    endfunction

    function automatic logic [7:0] strobes();
        return {q13_valid, q12_valid, q11_valid, q10_valid,
                q03_valid, q02_valid, q01_valid, q00_valid};
    endfunction

    // Advance one cycle, then sample: strobe cycles pop the scoreboard,
    // pulses are tallied.
    task automatic tick();
        logic [7:0] sv;
        @(posedge clk);
        #1;
        sv = strobes();
        if (sv != 8'h00) begin
            issue_cnt++;
            check("strobes_together", FW'(sv), FW'(8'hFF));
            check("issue_state", FW'(dbg_state), FW'(ISSUE));
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_issue observed=issue expected=no_issue");
            end
            if (exp_q.size() != 0) begin
                check("issue_operands", operands(), exp_q.pop_front());
            end
        end
        if (done) done_cnt++;
        if (err_framing) fr_cnt++;
        if (err_timeout) to_cnt++;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic send_frame(input logic [FW-1:0] f);
        exp_q.push_back(f);
        frames_sent++;
        for (int i = 0; i < 8; i++) begin
            send_beat(f[i*32 +: 32], (i == 7));
        end
    endtask

    // Full frame with a quick result: ends in LOAD with done high.
    task automatic run_frame(input logic [FW-1:0] f);
        send_frame(f);
        tick();
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [FW-1:0] f;
        logic [FW-1:0] fbad;
        int            d0, f0, t0;

        // Reset held across several edges.
        rst = 1'b1;
        repeat (3) tick();
        check("rst_s_ready", FW'(s_ready), '0);
        check("rst_flags", FW'({busy, done, err_framing, err_timeout}), '0);
        check("rst_frames", FW'(frames_issued), '0);
        check("rst_strobes", FW'(strobes()), '0);
        check("rst_operands", operands(), '0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", FW'(s_ready), FW'(1));

        // Clean frame.
        f = mk_frame(ONE, TWO, 32'h4040_0000, 32'h4080_0000, ONE, 32'h0, 32'h0, 32'h0);
        send_frame(f);
        check("f1_issue_latency", FW'(issue_cnt), FW'(1));
        check("f1_q00", FW'(q00), FW'(ONE));
        check("f1_q03", FW'(q03), FW'(32'h4080_0000));
        check("f1_q10", FW'(q10), FW'(ONE));
        check("f1_issue_ready", FW'(s_ready), '0);
        check("f1_issue_busy", FW'(busy), FW'(1));
        // A word offered during WAIT must not be taken.
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        tick();
        s_valid = 1'b0;
        s_data  = '0;
        check("f1_wait_state", FW'(dbg_state), FW'(WAIT));
        check("f1_frames", FW'(frames_issued), FW'(1));
        check("f1_wait_ready", FW'(s_ready), '0);
        check("f1_hold_q00", FW'(q00), FW'(ONE));
        check("f1_strobe_once", FW'(strobes()), '0);
        tick();
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        check("f1_done", FW'(done), FW'(1));
        check("f1_done_ready", FW'(s_ready), FW'(1));
        check("f1_done_busy", FW'(busy), '0);
        tick();
        check("f1_done_pulse", FW'(done_cnt), FW'(1));

        // Early s_last on the third word.
        send_beat(32'h1111_1111, 1'b0);
        send_beat(32'h2222_2222, 1'b0);
        send_beat(32'h3333_3333, 1'b1);
        check("early_framing", FW'(err_framing), FW'(1));
        tick();
        check("early_framing_pulse", FW'(fr_cnt), FW'(1));
        check("early_no_issue", FW'(issue_cnt), FW'(1));

        // Next clean frame, then let it time out.
        f = mk_frame(TWO, ONE, 32'h4110_0000, 32'h4120_0000,
                     32'hBF80_0000, 32'h3F00_0000, 32'h4040_0000, 32'hC000_0000);
        send_frame(f);
        check("f2_issue", FW'(issue_cnt), FW'(2));
        repeat (4) tick();
        check("f2_no_early_timeout", FW'(err_timeout), '0);
        check("f2_still_busy", FW'(busy), FW'(1));
        tick();
        check("f2_timeout", FW'(err_timeout), FW'(1));
        check("f2_timeout_nodone", FW'(done), '0);
        check("f2_timeout_ready", FW'(s_ready), FW'(1));
        tick();
        check("f2_timeout_pulse", FW'(to_cnt), FW'(1));

        // Eight words with no s_last, then two more ending the junk.
        fbad = mk_frame(32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                        32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007);
        for (int i = 0; i < 8; i++) begin
            send_beat(fbad[i*32 +: 32], 1'b0);
        end
        check("long_framing", FW'(err_framing), FW'(1));
        check("long_discard", FW'(dbg_state), FW'(DISCARD));
        check("long_discard_ready", FW'(s_ready), FW'(1));
        send_beat(32'hB000_0000, 1'b0);
        send_beat(32'hB000_0001, 1'b1);
        check("long_back_to_load", FW'(dbg_state), FW'(LOAD));
        check("long_framing_once", FW'(fr_cnt), FW'(2));
        check("long_no_issue", FW'(issue_cnt), FW'(2));
        check("discard_no_write", operands(), fbad);
        // Result strobe outside WAIT is ignored.
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        tick();
        check("res_outside_wait", FW'(done_cnt), FW'(1));

        // Clean frame with the result on the expiry cycle.
        f = mk_frame(ONE, ONE, ONE, ONE, TWO, TWO, TWO, TWO);
        send_frame(f);
        check("f3_issue", FW'(issue_cnt), FW'(3));
        repeat (4) tick();
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        check("f3_tie_done", FW'(done), FW'(1));
        check("f3_tie_no_timeout", FW'(err_timeout), '0);
        tick();
        check("f3_timeout_count", FW'(to_cnt), FW'(1));
        check("f3_done_count", FW'(done_cnt), FW'(2));

        // Counter wrap (CNT_W=4): 3 issued so far.
        for (int k = 0; k < 12; k++) begin
            f = mk_frame($urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom);
            run_frame(f);
        end
        check("frames_max", FW'(frames_issued), FW'(4'hF));
        f = mk_frame($urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom);
        run_frame(f);
        check("frames_wrap", FW'(frames_issued), '0);
        run_frame(mk_frame(ONE, TWO, ONE, TWO, TWO, ONE, TWO, ONE));
        check("frames_after_wrap", FW'(frames_issued), FW'(1));

        // Asynchronous reset after five words of a frame.
        for (int i = 0; i < 5; i++) begin
            send_beat(32'hC000_0000 + 32'(i), 1'b0);
        end
        d0 = done_cnt;
        f0 = fr_cnt;
        t0 = to_cnt;
        #2;
        rst = 1'b1;
        #1;
        check("arst_operands", operands(), '0);
        check("arst_frames", FW'(frames_issued), '0);
        check("arst_outputs", FW'({s_ready, busy, done, err_framing, err_timeout, strobes()}), '0);
        tick();
        tick();
        check("arst_no_pulses", FW'({d0, f0, t0}), FW'({done_cnt, fr_cnt, to_cnt}));
        rst = 1'b0;
        #1;
        check("arst_release_ready", FW'(s_ready), FW'(1));
        f = mk_frame(32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000,
                     32'h4140_0000, 32'h4150_0000, 32'h4160_0000, 32'h4170_0000);
        send_frame(f);
        tick();
        check("arst_frames_restart", FW'(frames_issued), FW'(1));
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        check("arst_final_done", FW'(done), FW'(1));
        tick();

        check("scoreboard_empty", FW'(exp_q.size()), '0);
        check("issue_total", FW'(issue_cnt), FW'(frames_sent));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
